// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS datapath (IF/ID/EX/MEM/WB).
// Latency: all outputs are combinational from state_q and inputs; state advances on each rising clk edge.
// Backpressure: IF and MEM hold while mem_ready=0, with no enables asserted.
// Ports: clk/reset (sync, active-high); opcode/funct are the IR fields; zero is the ALU flag; mem_ready is the memory handshake.
//        The outputs are the write enables (PCWr/IRWr/RegWr/MemWr), the mux selects (RegDst/WDSel/ALUSrc/PCSel), the ALU controls
//        (ALUOp/ExtOp), the current state (state_o) and the illegal-instruction pulse (illegal).
// Optional: define MC_CTRL_PERF_EN to add the cycle_cnt and instr_cnt performance counters (CNT_W bits wide).
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RegWr,
    output logic             MemWr,
    output logic [1:0]       RegDst,
    output logic [1:0]       WDSel,
    output logic             ALUSrc,
    output logic [2:0]       ALUOp,
    output logic [1:0]       ExtOp,
    output logic [1:0]       PCSel,
    output logic [2:0]       state_o,
    output logic             illegal
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Instruction decode from the IR fields held in the datapath.
    logic is_r, is_nop, is_addu, is_subu, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_exec;

    always_comb begin
        is_r    = (opcode == 6'b000000);
        is_nop  = is_r && (funct == 6'b000000);
        is_addu = is_r && (funct == 6'b100001);
        is_subu = is_r && (funct == 6'b100011);
        is_jr   = is_r && (funct == 6'b001000);
        is_ori  = (opcode == 6'b001101);
        is_lui  = (opcode == 6'b001111);
        is_lw   = (opcode == 6'b100011);
        is_sw   = (opcode == 6'b101011);
        is_beq  = (opcode == 6'b000100);
        is_j    = (opcode == 6'b000010);
        is_jal  = (opcode == 6'b000011);
        is_exec = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RegWr   = 1'b0;
        MemWr   = 1'b0;
        RegDst  = 2'b00;
        WDSel   = 2'b00;
        ALUSrc  = 1'b0;
        ALUOp   = 3'b000;
        ExtOp   = 2'b00;
        PCSel   = 2'b00;
        illegal = 1'b0;
        state_o = state_q;

        // ALU controls stay driven from EX through WB so the ALU result is stable
        // when MEM uses it as an address and WB writes it back.
        if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
            if (is_subu || is_beq) ALUOp = 3'b001;
            else if (is_ori)       ALUOp = 3'b010;
            else if (is_lui)       ALUOp = 3'b011;
            ALUSrc = is_ori | is_lui | is_lw | is_sw;
            if (is_lw || is_sw || is_beq) ExtOp = 2'b01;
        end

        case (state_q)
            S_IF: begin
                PCWr = mem_ready;
                IRWr = mem_ready;
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                state_d = S_IF;
                if (is_j || is_jal) begin
                    PCWr  = 1'b1;
                    PCSel = 2'b10;
                    if (is_jal) begin
                        // PC was already advanced in IF, so the link value is PC+4.
                        RegWr  = 1'b1;
                        RegDst = 2'b10;
                        WDSel  = 2'b10;
                    end
                end else if (is_jr) begin
                    PCWr  = 1'b1;
                    PCSel = 2'b11;
                end else if (is_exec) begin
                    state_d = S_EX;
                end else if (!is_nop) begin
                    illegal = 1'b1;
                end
            end
            S_EX: begin
                if (is_beq) begin
                    PCSel   = 2'b01;
                    PCWr    = zero;
                    state_d = S_IF;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    MemWr   = is_sw;
                    state_d = is_sw ? S_IF : S_WB;
                end
            end
            S_WB: begin
                RegWr   = 1'b1;
                RegDst  = is_r ? 2'b00 : 2'b01;
                WDSel   = is_lw ? 2'b01 : 2'b00;
                state_d = S_IF;
            end
            default: begin
                state_d = S_IF;
                state_o = 3'd0;
            end
        endcase

        // Reset overrides everything: abort the instruction with no write this cycle.
        if (reset) begin
            state_d = S_IF;
            PCWr    = 1'b0;
            IRWr    = 1'b0;
            RegWr   = 1'b0;
            MemWr   = 1'b0;
            RegDst  = 2'b00;
            WDSel   = 2'b00;
            ALUSrc  = 1'b0;
            ALUOp   = 3'b000;
            ExtOp   = 2'b00;
            PCSel   = 2'b00;
            illegal = 1'b0;
            state_o = 3'd0;
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        instr_cnt_d = instr_cnt_q;
        // An instruction retires when control returns to IF, unless it was rejected as illegal.
        if (state_q != S_IF && state_d == S_IF && !illegal)
            instr_cnt_d = instr_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    // Counters absent; CNT_W only sizes them when they are built.
    if (CNT_W > 0) begin : g_no_perf
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for mc_ctrl, checked with immediate assertions.
// Inputs change 2 time units after each rising edge; outputs are checked 1 unit later.
// Expected values come from hand-decoded instruction sequences.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       PCWr, IRWr, RegWr, MemWr, ALUSrc, illegal;
    logic [1:0] RegDst, WDSel, ExtOp, PCSel;
    logic [2:0] ALUOp, state_o;

    int n_assert = 0;
    int n_fail   = 0;

    mc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PCWr      (PCWr),
        .IRWr      (IRWr),
        .RegWr     (RegWr),
        .MemWr     (MemWr),
        .RegDst    (RegDst),
        .WDSel     (WDSel),
        .ALUSrc    (ALUSrc),
        .ALUOp     (ALUOp),
        .ExtOp     (ExtOp),
        .PCSel     (PCSel),
        .state_o   (state_o),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Enable group: {PCWr, IRWr, RegWr, MemWr, illegal}
    wire [4:0]  en  = {PCWr, IRWr, RegWr, MemWr, illegal};
    // Select group: {RegDst, WDSel, ALUSrc, ALUOp, ExtOp, PCSel}
    wire [11:0] sel = {RegDst, WDSel, ALUSrc, ALUOp, ExtOp, PCSel};

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Check state and enable group after a 1-unit settle.
    task automatic chk_se(input string tag, input logic [2:0] st, input logic [4:0] e);
        #1;
        check({tag, ".state"}, {13'd0, state_o}, {13'd0, st});
        check({tag, ".en"}, {11'd0, en}, {11'd0, e});
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
        opcode = 6'd0; funct = 6'd0;

        // Reset held for two cycles: everything reads 0.
        tick; chk_se("rst0", 3'd0, 5'b00000); check("rst0.sel", {4'd0, sel}, 16'd0);
        tick; chk_se("rst1", 3'd0, 5'b00000); check("rst1.sel", {4'd0, sel}, 16'd0);
        reset = 1'b0;
        chk_se("if_after_rst", 3'd0, 5'b11000); check("if.pcsel", {14'd0, PCSel}, 16'd0);

        // addu: IF, ID, EX, WB
        opcode = 6'b000000; funct = 6'b100001;
        tick; chk_se("addu.id", 3'd1, 5'b00000);
        tick; chk_se("addu.ex", 3'd2, 5'b00000);
        check("addu.ex.alu", {12'd0, ALUOp, ALUSrc}, {12'd0, 3'b000, 1'b0});
        tick; chk_se("addu.wb", 3'd4, 5'b00100);
        check("addu.wb.sel", {12'd0, RegDst, WDSel}, {12'd0, 2'b00, 2'b00});
        tick; chk_se("addu.done", 3'd0, 5'b11000);

        // lw: IF, ID, EX, MEM, WB
        opcode = 6'b100011; funct = 6'b000000;
        tick; chk_se("lw.id", 3'd1, 5'b00000);
        tick; chk_se("lw.ex", 3'd2, 5'b00000);
        check("lw.ex.alu", {10'd0, ALUOp, ALUSrc, ExtOp}, {10'd0, 3'b000, 1'b1, 2'b01});
        tick; chk_se("lw.mem", 3'd3, 5'b00000);
        tick; chk_se("lw.wb", 3'd4, 5'b00100);
        check("lw.wb.sel", {12'd0, RegDst, WDSel}, {12'd0, 2'b01, 2'b01});
        check("lw.wb.alu_held", {10'd0, ALUOp, ALUSrc, ExtOp}, {10'd0, 3'b000, 1'b1, 2'b01});
        tick; chk_se("lw.done", 3'd0, 5'b11000);

        // Memory waits: IF stall, then MEM stall for three cycles.
        mem_ready = 1'b0;
        chk_se("ifwait0", 3'd0, 5'b00000);
        tick; chk_se("ifwait1", 3'd0, 5'b00000);
        mem_ready = 1'b1;
        chk_se("ifwait.go", 3'd0, 5'b11000);
        tick; chk_se("lw2.id", 3'd1, 5'b00000);
        tick; chk_se("lw2.ex", 3'd2, 5'b00000);
        tick; mem_ready = 1'b0; chk_se("memwait0", 3'd3, 5'b00000);
        tick; chk_se("memwait1", 3'd3, 5'b00000);
        tick; chk_se("memwait2", 3'd3, 5'b00000);
        tick; mem_ready = 1'b1; chk_se("memwait3", 3'd3, 5'b00000);
        tick; chk_se("lw2.wb", 3'd4, 5'b00100);
        tick; chk_se("lw2.done", 3'd0, 5'b11000);

        // beq taken
        opcode = 6'b000100; zero = 1'b1;
        tick; chk_se("beq1.id", 3'd1, 5'b00000);
        tick; chk_se("beq1.ex", 3'd2, 5'b10000);
        check("beq1.ex.sel", {9'd0, ALUOp, PCSel, ExtOp}, {9'd0, 3'b001, 2'b01, 2'b01});
        tick; chk_se("beq1.done", 3'd0, 5'b11000);

        // beq not taken
        zero = 1'b0;
        tick; chk_se("beq0.id", 3'd1, 5'b00000);
        tick; chk_se("beq0.ex", 3'd2, 5'b00000);
        check("beq0.pcsel", {14'd0, PCSel}, 16'd1);
        tick; chk_se("beq0.done", 3'd0, 5'b11000);

        // jal
        opcode = 6'b000011;
        tick; chk_se("jal.id", 3'd1, 5'b10100);
        check("jal.sel", {10'd0, PCSel, RegDst, WDSel}, {10'd0, 2'b10, 2'b10, 2'b10});
        tick; chk_se("jal.done", 3'd0, 5'b11000);

        // j
        opcode = 6'b000010;
        tick; chk_se("j.id", 3'd1, 5'b10000);
        check("j.pcsel", {14'd0, PCSel}, 16'd2);
        tick; chk_se("j.done", 3'd0, 5'b11000);

        // jr
        opcode = 6'b000000; funct = 6'b001000;
        tick; chk_se("jr.id", 3'd1, 5'b10000);
        check("jr.pcsel", {14'd0, PCSel}, 16'd3);
        tick; chk_se("jr.done", 3'd0, 5'b11000);

        // nop: straight back to IF, not illegal
        funct = 6'b000000;
        tick; chk_se("nop.id", 3'd1, 5'b00000);
        tick; chk_se("nop.done", 3'd0, 5'b11000);

        // Undefined opcode: one-cycle illegal pulse in ID
        opcode = 6'b111111;
        tick; chk_se("ill.id", 3'd1, 5'b00001);
        tick; chk_se("ill.done", 3'd0, 5'b11000);

        // ori: WB writes rt with zero-extended immediate kept on the ALU
        opcode = 6'b001101;
        tick; chk_se("ori.id", 3'd1, 5'b00000);
        tick; chk_se("ori.ex", 3'd2, 5'b00000);
        check("ori.alu", {10'd0, ALUOp, ALUSrc, ExtOp}, {10'd0, 3'b010, 1'b1, 2'b00});
        tick; chk_se("ori.wb", 3'd4, 5'b00100);
        check("ori.wb.sel", {12'd0, RegDst, WDSel}, {12'd0, 2'b01, 2'b00});
        tick; chk_se("ori.done", 3'd0, 5'b11000);

        // sw with reset asserted during MEM: no write, next state IF
        opcode = 6'b101011;
        tick; chk_se("sw.id", 3'd1, 5'b00000);
        tick; chk_se("sw.ex", 3'd2, 5'b00000);
        tick; chk_se("sw.mem", 3'd3, 5'b00010);
        reset = 1'b1;
        chk_se("sw.mem.rst", 3'd0, 5'b00000);
        tick; reset = 1'b0;
        chk_se("sw.after_rst", 3'd0, 5'b11000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
